// File: rtl/credential_sender.sv
// -----------------------------------------------------------------------------
// credential_sender
//
// Transmit side of the access-control link. Keypad digits are assembled into
// 16-bit words and sent to the receiver as {change_flag, payload} on a 17-bit
// bus. Each word is qualified by a one-cycle load strobe. Load strobes are
// always separated by enough idle cycles for the receiver to get back to its
// load-sampling state. After a plain (non-change) password the sender watches
// access_grant. If no grant arrives in time, that counts as a failed attempt
// and the sender waits for a new password. It locks out after MAX_TRIES
// failed attempts.
//
// Optional feature macro: CREDENTIAL_SENDER_KEY_CLEAR_EN
//   defined   : key_clear zeroes the word being entered (ENTER_* states only)
//   undefined : key_clear is ignored (the port is still present)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   key_valid     strobe, key_code holds a hex digit
//   key_code[3:0] hex digit
//   key_enter     strobe, current word complete
//   key_clear     strobe, discard partial word (optional feature)
//   change_req    sampled with the ID key_enter, requests a password change
//   access_grant  grant level from the receiver
//   data_out[16:0] word to receiver: [16] change flag, [15:0] payload
//   data_load     one-cycle strobe qualifying data_out
//   busy          high outside IDLE / GRANTED / LOCKED
//   granted       high in GRANTED
//   locked        high in LOCKED
//   tries[2:0]    failed password attempts so far
// -----------------------------------------------------------------------------
module credential_sender #(
  parameter int GAP_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 16,
  parameter int MAX_TRIES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_enter,
  input  logic        key_clear,
  input  logic        change_req,
  input  logic        access_grant,
  output logic [16:0] data_out,
  output logic        data_load,
  output logic        busy,
  output logic        granted,
  output logic        locked,
  output logic [2:0]  tries
);

  // Counter widths only need to hold the last count value (N-1).
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RESP_TIMEOUT - 1);
  localparam logic [2:0]    TRIES_MAX = 3'(MAX_TRIES);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ENTER_ID  = 4'd1,
    S_SEND_ID   = 4'd2,
    S_GAP       = 4'd3,
    S_ENTER_PW  = 4'd4,
    S_SEND_PW   = 4'd5,
    S_WAIT_RESP = 4'd6,
    S_ENTER_NEW = 4'd7,
    S_SEND_NEW  = 4'd8,
    S_GRANTED   = 4'd9,
    S_LOCKED    = 4'd10
  } state_t;

  state_t          r_state;
  state_t          r_next;      // state to resume once the GAP has elapsed
  logic [15:0]     r_word;
  logic            r_chg;
  logic [GW-1:0]   r_gap_cnt;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_tries;
  logic [16:0]     r_data_out;
  logic            r_data_load;
  logic            r_busy;
  logic            r_granted;
  logic            r_locked;

  logic            w_clr;
  logic [15:0]     w_word_base;
  logic [15:0]     w_word_entry;
  logic [2:0]      w_tries_inc;

`ifdef CREDENTIAL_SENDER_KEY_CLEAR_EN
  assign w_clr = key_clear;
`else
  logic w_unused_key_clear;
  assign w_unused_key_clear = key_clear;
  assign w_clr = 1'b0;
`endif

  // While a word is being entered, a clear applies before a digit shift in the same cycle.
  assign w_word_base  = w_clr ? 16'h0000 : r_word;
  assign w_word_entry = key_valid ? {w_word_base[11:0], key_code} : w_word_base;
  assign w_tries_inc  = r_tries + 3'd1;

  // Main FSM: state, word assembly, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_next      <= S_IDLE;
      r_word      <= 16'h0000;
      r_chg       <= 1'b0;
      r_gap_cnt   <= {GW{1'b0}};
      r_timer     <= {TW{1'b0}};
      r_tries     <= 3'd0;
      r_data_out  <= 17'h00000;
      r_data_load <= 1'b0;
      r_busy      <= 1'b0;
      r_granted   <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_data_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_word  <= {r_word[11:0], key_code};
            r_state <= S_ENTER_ID;
            r_busy  <= 1'b1;
          end
        end
        S_ENTER_ID: begin
          // A digit arriving with enter is shifted before the word is taken.
          r_word <= w_word_entry;
          if (key_enter) begin
            r_chg   <= change_req;
            r_state <= S_SEND_ID;
          end
        end
        S_SEND_ID: begin
          r_data_out  <= {r_chg, r_word};
          r_data_load <= 1'b1;
          r_word      <= 16'h0000;
          r_next      <= S_ENTER_PW;
          r_gap_cnt   <= {GW{1'b0}};
          r_state     <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= r_next;
            r_busy  <= (r_next != S_IDLE);
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        S_ENTER_PW: begin
          r_word <= w_word_entry;
          if (key_enter) begin
            r_state <= S_SEND_PW;
          end
        end
        S_SEND_PW: begin
          r_data_out  <= {1'b0, r_word};
          r_data_load <= 1'b1;
          r_word      <= 16'h0000;
          if (r_chg) begin
            // A change-request password is not answered by the receiver.
            r_next    <= S_ENTER_NEW;
            r_gap_cnt <= {GW{1'b0}};
            r_state   <= S_GAP;
          end else begin
            r_timer <= {TW{1'b0}};
            r_state <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // Grant is checked first so it wins over a coincident timeout.
          if (access_grant) begin
            r_state   <= S_GRANTED;
            r_busy    <= 1'b0;
            r_granted <= 1'b1;
          end else if (r_timer == TMO_LAST) begin
            if (r_tries != TRIES_MAX) begin
              r_tries <= w_tries_inc;
            end
            if (w_tries_inc == TRIES_MAX) begin
              r_state  <= S_LOCKED;
              r_busy   <= 1'b0;
              r_locked <= 1'b1;
            end else begin
              r_next    <= S_ENTER_PW;
              r_gap_cnt <= {GW{1'b0}};
              r_state   <= S_GAP;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ENTER_NEW: begin
          r_word <= w_word_entry;
          if (key_enter) begin
            r_state <= S_SEND_NEW;
          end
        end
        S_SEND_NEW: begin
          r_data_out  <= {1'b0, r_word};
          r_data_load <= 1'b1;
          r_word      <= 16'h0000;
          r_chg       <= 1'b0;
          r_tries     <= 3'd0;
          r_next      <= S_IDLE;
          r_gap_cnt   <= {GW{1'b0}};
          r_state     <= S_GAP;
        end
        S_GRANTED: begin
          r_state <= S_GRANTED;
        end
        S_LOCKED: begin
          r_state <= S_LOCKED;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_granted <= 1'b0;
          r_locked  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign data_load = r_data_load;
  assign busy      = r_busy;
  assign granted   = r_granted;
  assign locked    = r_locked;
  assign tries     = r_tries;

endmodule

// File: tb/tb_credential_sender.sv
// -----------------------------------------------------------------------------
// tb_credential_sender
//
// Directed and randomized checks of credential_sender. The expected load
// words come from a keypad model: each digit gives w = (w*16 + d) mod 65536.
// Expected attempt counts are kept as plain integers.
// -----------------------------------------------------------------------------
module tb_credential_sender;

  localparam int GAP  = 2;
  localparam int TMO  = 16;
  localparam int MAXT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_enter;
  logic        key_clear;
  logic        change_req;
  logic        access_grant;
  logic [16:0] data_out;
  logic        data_load;
  logic        busy;
  logic        granted;
  logic        locked;
  logic [2:0]  tries;

  int tests = 0;
  int fails = 0;

  logic [16:0] load_q[$];
  logic        prev_load = 1'b0;

  credential_sender #(
    .GAP_CYCLES  (GAP),
    .RESP_TIMEOUT(TMO),
    .MAX_TRIES   (MAXT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .change_req  (change_req),
    .access_grant(access_grant),
    .data_out    (data_out),
    .data_load   (data_load),
    .busy        (busy),
    .granted     (granted),
    .locked      (locked),
    .tries       (tries)
  );

  always #5 clk = ~clk;

  // Capture every load pulse and check that no two pulses are adjacent.
  always @(negedge clk) begin
    if (data_load === 1'b1) begin
      load_q.push_back(data_out);
      tests++;
      assert (prev_load === 1'b0) else begin
        fails++;
        $error("FAIL back_to_back_load: observed %0b expected 0", prev_load);
      end
    end
    prev_load = data_load;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic key(input int d);
    key_valid = 1'b1;
    key_code  = d[3:0];
    tick();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter(input logic chg);
    key_enter  = 1'b1;
    change_req = chg;
    tick();
    key_enter  = 1'b0;
    change_req = 1'b0;
  endtask

  task automatic pulse_clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  // Type a digit sequence and return the word the keypad model predicts.
  task automatic type_seq(input int digs[$], output int exp);
    exp = 0;
    foreach (digs[i]) begin
      exp = (exp * 16 + digs[i]) % 65536;
      key(digs[i]);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic type_rand(output int exp);
    int q[$];
    int n;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 15));
    type_seq(q, exp);
  endtask

  task automatic expect_load(input string tag, input logic [16:0] exp);
    int i;
    i = 0;
    while (load_q.size() == 0 && i < 40) begin
      tick();
      i++;
    end
    check({tag, "_present"}, (load_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (load_q.size() > 0) check(tag, load_q.pop_front(), exp);
  endtask

  task automatic expect_none(input string tag);
    check(tag, load_q.size(), 32'd0);
    load_q.delete();
  endtask

  task automatic after_gap();
    repeat (GAP + 1) tick();
  endtask

  task automatic do_reset();
    access_grant = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_q.delete();
    check("rst_data_out", data_out, 32'd0);
    check("rst_data_load", data_load, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_granted", granted, 32'd0);
    check("rst_locked", locked, 32'd0);
    check("rst_tries", tries, 32'd0);
  endtask

  // Password attempt that gets no grant; exp_tries is the model's count.
  task automatic fail_attempt(inout int exp_tries);
    int pw;
    type_rand(pw);
    enter(1'b0);
    expect_load("fail_pw", {1'b0, pw[15:0]});
    repeat (TMO + GAP + 2) tick();
    if (exp_tries < MAXT) exp_tries++;
    check("fail_tries", tries, exp_tries);
    check("fail_locked", locked, (exp_tries == MAXT) ? 32'd1 : 32'd0);
    check("fail_busy", busy, (exp_tries == MAXT) ? 32'd0 : 32'd1);
    expect_none("fail_no_extra_load");
  endtask

  initial begin
    int q[$];
    int w;
    int w2;
    int nt;
    int nfail;
    int k;
    logic c;

    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0;
    key_clear = 1'b0; change_req = 1'b0; access_grant = 1'b0;
    tick();
    do_reset();

    // Change flow: three pulses, no response wait, back to IDLE.
    q = '{0, 0, 4, 2}; type_seq(q, w); enter(1'b1);
    expect_load("chg_id", 17'h10042);
    after_gap();
    q = '{1, 1, 1, 1}; type_seq(q, w); enter(1'b0);
    expect_load("chg_pw", 17'h01111);
    after_gap();
    q = '{2, 2, 2, 2}; type_seq(q, w); enter(1'b0);
    expect_load("chg_new", 17'h02222);
    repeat (GAP + 2) tick();
    check("chg_idle_busy", busy, 32'd0);
    check("chg_tries", tries, 32'd0);
    check("chg_granted", granted, 32'd0);
    expect_none("chg_no_extra");

    // Reset landing on the SEND_ID cycle.
    key(5); key(6); enter(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_load", data_load, 32'd0);
    check("midrst_busy", busy, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    repeat (4) tick();
    expect_none("midrst_no_load");

    // Normal grant, arriving 5 cycles after the password pulse.
    q = '{1, 2, 3, 4}; type_seq(q, w); enter(1'b0);
    expect_load("grant_id", 17'h01234);
    after_gap();
    q = '{10, 11, 12, 13}; type_seq(q, w); enter(1'b0);
    expect_load("grant_pw", 17'h0ABCD);
    repeat (4) tick();
    access_grant = 1'b1;
    tick(); tick();
    check("grant_granted", granted, 32'd1);
    check("grant_busy", busy, 32'd0);
    access_grant = 1'b0;
    repeat (3) tick();
    check("grant_held", granted, 32'd1);
    expect_none("grant_no_extra");
    do_reset();

    // Short words, timeouts, then lockout.
    q = '{7}; type_seq(q, w); enter(1'b0);
    expect_load("short_id", 17'h00007);
    after_gap();
    q = '{5}; type_seq(q, w); enter(1'b0);
    expect_load("short_pw", 17'h00005);
    repeat (TMO + GAP + 2) tick();
    nt = 1;
    check("timeout_tries", tries, 32'd1);
    check("timeout_busy", busy, 32'd1);
    expect_none("timeout_no_extra");
    while (nt < MAXT) fail_attempt(nt);
    check("lock_tries", tries, 32'd4);
    key(1); key(2); enter(1'b0);
    repeat (10) tick();
    expect_none("lock_ignores_keys");
    check("lock_held", locked, 32'd1);
    do_reset();

    // Grant in the same cycle as the timeout: grant wins.
    type_rand(w); enter(1'b0);
    expect_load("edge_id", {1'b0, w[15:0]});
    after_gap();
    type_rand(w); enter(1'b0);
    expect_load("edge_pw", {1'b0, w[15:0]});
    repeat (TMO - 2) tick();
    access_grant = 1'b1;
    tick(); tick();
    check("edge_granted", granted, 32'd1);
    check("edge_tries", tries, 32'd0);
    do_reset();

    // key_clear in the middle of ID entry.
    key(9); key(9); pulse_clear(); key(3); enter(1'b0);
`ifdef CREDENTIAL_SENDER_KEY_CLEAR_EN
    expect_load("clear_id", 17'h00003);
`else
    expect_load("clear_id", 17'h00993);
`endif
    do_reset();

    // Randomized sessions.
    for (int it = 0; it < 8; it++) begin
      c = 1'($urandom_range(0, 1));
      type_rand(w); enter(c);
      expect_load("rnd_id", {c, w[15:0]});
      after_gap();
      if (c) begin
        type_rand(w); enter(1'b0);
        expect_load("rnd_chg_pw", {1'b0, w[15:0]});
        after_gap();
        type_rand(w2); enter(1'b0);
        expect_load("rnd_chg_new", {1'b0, w2[15:0]});
        repeat (GAP + 2) tick();
        check("rnd_chg_idle", busy, 32'd0);
      end else begin
        nfail = $urandom_range(0, MAXT);
        nt = 0;
        while (nt < nfail) fail_attempt(nt);
        if (nt < MAXT) begin
          type_rand(w); enter(1'b0);
          expect_load("rnd_pw", {1'b0, w[15:0]});
          k = $urandom_range(0, TMO - 2);
          repeat (k) tick();
          access_grant = 1'b1;
          tick(); tick();
          check("rnd_granted", granted, 32'd1);
          check("rnd_tries", tries, nt);
        end else begin
          check("rnd_locked", locked, 32'd1);
        end
      end
      do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/credential_sender.md
Name: credential_sender

Overview:
- Transmit-side counterpart of the access-control receiver. Collects keypad digits, assembles 16-bit words, and drives the receiver's `{change_flag, user_id}` / password word stream.
- Each word is presented on a 17-bit data bus with a one-cycle load strobe, spaced so the receiver can reach its load-sampling state.
- Monitors the receiver's access-grant line, retries the password on denial or timeout, and locks out after a bounded number of attempts.

Parameters:
- GAP_CYCLES, 2, idle cycles inserted after any load pulse before the next load pulse (minimum 1).
- RESP_TIMEOUT, 16, cycles to wait for access_grant after a non-change password send before declaring denial.
- MAX_TRIES, 4, password attempts allowed before lockout (1..7).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key_code is valid
- key_code  in  4  hex digit entered
- key_enter  in  1  one-cycle strobe; current word complete
- key_clear  in  1  one-cycle strobe; discard partial word (see Optional Feature)
- change_req  in  1  sampled at ID key_enter; requests a password change
- access_grant  in  1  grant level from the receiver
- data_out  out  17  word to the receiver: bit16 = change flag, bits15:0 = payload
- data_load  out  1  one-cycle strobe; data_out is valid
- busy  out  1  high in any state except IDLE, GRANTED and LOCKED
- granted  out  1  high while in GRANTED
- locked  out  1  high while in LOCKED
- tries  out  3  failed attempts so far

Behaviour:
- Reset (rst high at a clock edge) values: state=IDLE, data_out=0, data_load=0, busy=0, granted=0, locked=0, tries=0, word register=0, change register=0. Reset takes priority in every state, including mid-send.
- Word entry: on key_valid, word <= {word[11:0], key_code}. Only the last 4 digits are kept. Fewer than 4 digits leaves the upper nibbles 0. key_valid and key_enter in the same cycle: the digit is shifted first, then the word is taken.
- States and transitions:
  - IDLE: first key_valid -> ENTER_ID, and that digit is shifted in.
  - ENTER_ID: on key_enter, latch chg <= change_req -> SEND_ID.
  - SEND_ID: data_out <= {chg, word}; data_load=1 for exactly one cycle; clear word -> GAP(next=ENTER_PW).
  - GAP: counts GAP_CYCLES with data_load=0, then goes to the latched next state.
  - ENTER_PW: on key_enter -> SEND_PW.
  - SEND_PW: data_out <= {1'b0, word}; one-cycle data_load; clear word.
    - chg=1 -> GAP(next=ENTER_NEW).
    - chg=0 -> WAIT_RESP with timer=0.
  - WAIT_RESP:
    - access_grant=1 -> GRANTED.
    - Timer reaching RESP_TIMEOUT-1 with no grant counts as a failure: tries+1.
    - After a failure: if tries+1 == MAX_TRIES -> LOCKED, else GAP(next=ENTER_PW).
    - Grant arriving in the same cycle as the timeout: the grant wins.
  - ENTER_NEW: on key_enter -> SEND_NEW.
  - SEND_NEW: data_out <= {1'b0, word}; one-cycle data_load -> GAP(next=IDLE). chg and tries are cleared.
  - GRANTED: held until rst.
  - LOCKED: held until rst. All key inputs are ignored.
- data_out holds its last value between pulses. data_load is never high on two consecutive cycles.
- key_valid / key_enter arriving in the SEND_*, GAP or WAIT_RESP states are ignored.
- tries saturates at MAX_TRIES.

Optional Feature:
- Macro: CREDENTIAL_SENDER_KEY_CLEAR_EN.
- Defined: key_clear in ENTER_ID, ENTER_PW or ENTER_NEW zeroes the word register and keeps the state.
  - key_clear together with key_valid: clear first, then shift.
  - key_clear together with key_enter: sends 0.
- Undefined: key_clear is ignored entirely. The port remains on the interface.

Test Plan:
- Reset mid-send: rst asserted in the SEND_ID cycle -> next cycle data_load=0, busy=0, data_out=0, state IDLE.
- Normal grant: digits 1,2,3,4, enter (change_req=0); digits A,B,C,D, enter; access_grant rises 5 cycles after the second pulse.
  - Expect data_out=0x01234 with one data_load pulse.
  - Expect at least GAP_CYCLES idle cycles, then data_out=0x0ABCD with one pulse.
  - Expect granted=1 and busy=0.
- Short word and timeout: ID digits 7, enter; password digits 5, enter; access_grant held 0.
  - Expect data_out=0x00007, then 0x00005.
  - After 16 cycles: tries=1, back in ENTER_PW, no extra data_load.
- Lockout: 4 consecutive timeouts with MAX_TRIES=4 -> locked=1, tries=4; subsequent key_enter produces no data_load.
- Change flow: change_req=1 at ID enter with ID 0x0042; password 0x1111; new password 0x2222.
  - Expect three pulses: 0x10042, 0x01111, 0x02222.
  - Expect no WAIT_RESP, then return to IDLE.
- Clear feature: digits 9,9, key_clear, digit 3, enter.
  - With the macro defined: sends 0x00003.
  - Without the macro: sends 0x00993.
